// File: rtl/maxpool_nxn_relu.sv
// Streaming NxN max/average pooling with optional ReLU over feature maps held in an external
// memory. Issues one read per cycle and writes one pooled result per completed window.
module maxpool_nxn_relu #(
  parameter int unsigned LAYER_WIDTH  = 10,
  parameter int unsigned LAYER_HEIGHT = 20,
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned DATA_WIDTH   = 27,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned POOL_SIZE    = 2,
  parameter int unsigned STRIDE       = 2,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  relu_en,
  input  logic                  avg_mode,
  input  logic [DATA_WIDTH-1:0] data_0_in,
  output logic [ADDR_WIDTH-1:0] read_address_0_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [ADDR_WIDTH-1:0] write_address_out,
  output logic                  we_out,
  output logic                  busy,
  output logic                  maxrelu_done
);

  localparam int unsigned OW    = (LAYER_WIDTH - POOL_SIZE) / STRIDE + 1;
  localparam int unsigned OH    = (LAYER_HEIGHT - POOL_SIZE) / STRIDE + 1;
  localparam int unsigned FRAME = LAYER_WIDTH * LAYER_HEIGHT;
  localparam int unsigned SHIFT = 2 * $clog2(POOL_SIZE);
  localparam int unsigned ACC_W = DATA_WIDTH + SHIFT;
  localparam int unsigned RL    = READ_LATENCY;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic [31:0] ch_q, ch_d, row_q, row_d, col_q, col_d, ky_q, ky_d, kx_q, kx_d;
  logic        accept, last_read, tag_v, tag_f, tag_l;
  // Stage 0 travels with the address; stage RL lines up with data_0_in.
  logic [RL:0] tv_q, tf_q, tl_q;
  logic        relu_q, avg_q;
  logic [ADDR_WIDTH-1:0] wcnt_q;

  logic signed [ACC_W-1:0]      acc_q, acc_nxt, data_ext;
  logic signed [DATA_WIDTH-1:0] pooled, result_nxt;
  logic                         consume, win_end;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [31:0] c, input logic [31:0] r,
                                                    input logic [31:0] col, input logic [31:0] ky,
                                                    input logic [31:0] kx);
    return ADDR_WIDTH'(c * FRAME + (r * STRIDE + ky) * LAYER_WIDTH + col * STRIDE + kx);
  endfunction

  assign last_read = (ch_q == CHANNELS - 1) && (row_q == OH - 1) && (col_q == OW - 1) &&
                     (ky_q == POOL_SIZE - 1) && (kx_q == POOL_SIZE - 1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    accept  = 1'b0;
    tag_v   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          accept  = 1'b1;
          tag_v   = 1'b1;
          state_d = StIssue;
          ch_d    = '0;
          row_d   = '0;
          col_d   = '0;
          ky_d    = '0;
          kx_d    = '0;
        end
      end
      StIssue: begin
        if (last_read) begin
          state_d = StDrain;
        end else begin
          tag_v = 1'b1;
          if (kx_q != POOL_SIZE - 1) begin
            kx_d = kx_q + 32'd1;
          end else begin
            kx_d = '0;
            if (ky_q != POOL_SIZE - 1) begin
              ky_d = ky_q + 32'd1;
            end else begin
              ky_d = '0;
              if (col_q != OW - 1) begin
                col_d = col_q + 32'd1;
              end else begin
                col_d = '0;
                if (row_q != OH - 1) begin
                  row_d = row_q + 32'd1;
                end else begin
                  row_d = '0;
                  ch_d  = ch_q + 32'd1;
                end
              end
            end
          end
        end
      end
      // The final write is on the bus once nothing is left in flight.
      StDrain: if (we_out && (tv_q == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    tag_f = tag_v && (kx_d == '0) && (ky_d == '0);
    tag_l = tag_v && (kx_d == POOL_SIZE - 1) && (ky_d == POOL_SIZE - 1);
  end

  assign consume = tv_q[RL];
  assign win_end = tv_q[RL] && tl_q[RL];

  always_comb begin
    data_ext = {{SHIFT{data_0_in[DATA_WIDTH-1]}}, data_0_in};
    if (tf_q[RL]) begin
      acc_nxt = data_ext;
    end else if (avg_q) begin
      acc_nxt = acc_q + data_ext;
    end else begin
      acc_nxt = (data_ext > acc_q) ? data_ext : acc_q;
    end
    // Arithmetic shift floors toward minus infinity, as intended for the average.
    pooled     = avg_q ? DATA_WIDTH'(acc_nxt >>> SHIFT) : DATA_WIDTH'(acc_nxt);
    result_nxt = (relu_q && pooled[DATA_WIDTH-1]) ? '0 : pooled;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= StIdle;
      ch_q               <= '0;
      row_q              <= '0;
      col_q              <= '0;
      ky_q               <= '0;
      kx_q               <= '0;
      tv_q               <= '0;
      tf_q               <= '0;
      tl_q               <= '0;
      relu_q             <= 1'b0;
      avg_q              <= 1'b0;
      wcnt_q             <= '0;
      acc_q              <= '0;
      read_address_0_out <= '0;
      result_out         <= '0;
      write_address_out  <= '0;
      we_out             <= 1'b0;
    end else begin
      state_q            <= state_d;
      ch_q               <= ch_d;
      row_q              <= row_d;
      col_q              <= col_d;
      ky_q               <= ky_d;
      kx_q               <= kx_d;
      read_address_0_out <= addr_of(ch_d, row_d, col_d, ky_d, kx_d);
      tv_q               <= {tv_q[RL-1:0], tag_v};
      tf_q               <= {tf_q[RL-1:0], tag_f};
      tl_q               <= {tl_q[RL-1:0], tag_l};
      we_out             <= win_end;
      if (accept) begin
        relu_q <= relu_en;
        avg_q  <= avg_mode;
        wcnt_q <= '0;
      end
      if (consume) acc_q <= acc_nxt;
      if (win_end) begin
        result_out        <= result_nxt;
        write_address_out <= wcnt_q;
        wcnt_q            <= wcnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign busy         = (state_q == StIssue) || (state_q == StDrain);
  assign maxrelu_done = (state_q == StDone);

endmodule

// File: tb/tb_maxpool_nxn_relu.sv
// Randomised scoreboard bench for maxpool_nxn_relu: default-parameter instance against a
// window-level reference model, plus a small two-channel stride-1 instance.
module tb_maxpool_nxn_relu;
  localparam int LW = 10, LH = 20, DW = 27, AW = 10, P = 2, S = 2, RL = 2;
  localparam int OW = (LW - P) / S + 1;
  localparam int OH = (LH - P) / S + 1;
  localparam int NRD = OW * OH * P * P;

  logic clk = 1'b0;
  logic reset, run, relu_en, avg_mode, run_b;
  logic [DW-1:0] data_a, res_a, data_b, res_b;
  logic [AW-1:0] rd_a, wa_a, rd_b, wa_b;
  logic we_a, busy_a, done_a, we_b, busy_b, done_b;

  always #5 clk = ~clk;

  maxpool_nxn_relu dut_a (
    .clk(clk), .reset(reset), .run(run), .relu_en(relu_en), .avg_mode(avg_mode),
    .data_0_in(data_a), .read_address_0_out(rd_a), .result_out(res_a),
    .write_address_out(wa_a), .we_out(we_a), .busy(busy_a), .maxrelu_done(done_a)
  );

  maxpool_nxn_relu #(
    .LAYER_WIDTH(4), .LAYER_HEIGHT(4), .CHANNELS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .POOL_SIZE(2), .STRIDE(1), .READ_LATENCY(3)
  ) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .relu_en(1'b1), .avg_mode(1'b0),
    .data_0_in(data_b), .read_address_0_out(rd_b), .result_out(res_b),
    .write_address_out(wa_b), .we_out(we_b), .busy(busy_b), .maxrelu_done(done_b)
  );

  // Memory models: data appears RL cycles after the address.
  logic signed [DW-1:0] mem [1 << AW];
  logic [AW-1:0] pipe_a [RL];
  logic [AW-1:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a[0] <= rd_a;
    for (int i = 1; i < RL; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= rd_b;
    for (int i = 1; i < 3; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign data_a = mem[pipe_a[RL-1]];
  assign data_b = {{(DW-AW){1'b0}}, pipe_b[2]};

  int n_checks = 0, n_fail = 0;
  int tcyc = 0, t0 = 0, t0b = 0, mk, mkb, exp_done = -1;
  bit active = 0, active_b = 0;
  int wcnt_b, bi, bc, br, bcol, bky, bkx;

  typedef struct {int addr; int val; int cyc;} wr_t;
  wr_t exp_q[$];
  int  exp_rd[$];

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: evaluate every window straight from the memory contents.
  task automatic build(input bit relu, input bit avg);
    int a, v, s, m, q, res, w;
    exp_q.delete();
    exp_rd.delete();
    for (int r = 0; r < OH; r++) begin
      for (int col = 0; col < OW; col++) begin
        s = 0;
        m = 0;
        for (int ky = 0; ky < P; ky++) begin
          for (int kx = 0; kx < P; kx++) begin
            a = (r * S + ky) * LW + col * S + kx;
            exp_rd.push_back(a);
            v = int'(mem[a]);
            if ((ky == 0 && kx == 0) || v > m) m = v;
            s += v;
          end
        end
        q = s / (P * P);
        if (s < 0 && q * (P * P) != s) q--;
        res = avg ? q : m;
        if (relu && res < 0) res = 0;
        w = r * OW + col;
        exp_q.push_back('{w, res, (w + 1) * P * P + RL + 1});
      end
    end
    exp_done = NRD + RL + 2;
  endtask

  task automatic start(input bit relu, input bit avg);
    build(relu, avg);
    @(negedge clk);
    run = 1'b1;
    relu_en = relu;
    avg_mode = avg;
    @(posedge clk);
    t0 = tcyc;
    active = 1'b1;
    @(negedge clk);
    run = 1'b0;
    relu_en = ~relu;
    avg_mode = ~avg;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && active; i++) @(negedge clk);
    if (active) begin
      check("done_timeout", 0, 1);
      active = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_addr", int'(rd_a), 0);
    check("rst_result", int'(res_a), 0);
    check("rst_wr_addr", int'(wa_a), 0);
    check("rst_we", int'(we_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
  endtask

  // Monitor for the default instance: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (reset) begin
      mk = tcyc - t0;
      if (active) begin
        check("busy", int'(busy_a), int'(mk >= 1 && mk <= NRD + RL + 1));
        if (mk >= 1 && mk <= NRD) check("rd_addr", int'(rd_a), exp_rd[mk-1]);
      end
      if (we_a) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          check("wr_addr", int'(wa_a), exp_q[0].addr);
          check("wr_data", int'($signed(res_a)), exp_q[0].val);
          check("wr_cycle", mk, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
      if (done_a) begin
        check("done_cycle", mk, exp_done);
        check("writes_left", exp_q.size(), 0);
        exp_done = -1;
        active = 1'b0;
      end
    end
  end

  // Monitor for the 2-channel 4x4 stride-1 instance; data equals address, so each window's
  // maximum is its bottom-right element.
  always @(negedge clk) begin
    if (reset && active_b) begin
      mkb = tcyc - t0b;
      if (mkb >= 1 && mkb <= 72) begin
        bi = mkb - 1;
        bkx = bi % 2;
        bky = (bi / 2) % 2;
        bcol = (bi / 4) % 3;
        br = (bi / 12) % 3;
        bc = bi / 36;
        check("b_rd_addr", int'(rd_b), bc * 16 + (br + bky) * 4 + bcol + bkx);
      end
      if (we_b) begin
        bc = wcnt_b / 9;
        br = (wcnt_b / 3) % 3;
        bcol = wcnt_b % 3;
        check("b_wr_addr", int'(wa_b), wcnt_b);
        check("b_wr_data", int'($signed(res_b)), bc * 16 + (br + 1) * 4 + bcol + 1);
        check("b_wr_cycle", mkb, (wcnt_b + 1) * 4 + 3 + 1);
        wcnt_b++;
      end
      if (done_b) begin
        check("b_done_cycle", mkb, 77);
        check("b_writes", wcnt_b, 18);
        check("b_busy_at_done", int'(busy_b), 0);
        active_b = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b0;
    run = 1'b0;
    run_b = 1'b0;
    relu_en = 1'b0;
    avg_mode = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Data equals address, max pooling with ReLU.
    start(1'b1, 1'b0);
    wait_done();

    // Uniform negative input, with and without ReLU.
    for (int i = 0; i < 200; i++) mem[i] = DW'(-5);
    start(1'b1, 1'b0);
    wait_done();
    start(1'b0, 1'b0);
    wait_done();

    // Average mode with known floor-rounding windows, rest random.
    for (int i = 0; i < 200; i++) mem[i] = DW'($urandom);
    mem[0] = DW'(4);  mem[1] = DW'(8);  mem[10] = DW'(-12); mem[11] = DW'(1);
    mem[2] = DW'(-1); mem[3] = DW'(-1); mem[12] = DW'(-1);  mem[13] = DW'(-2);
    start(1'b0, 1'b1);
    wait_done();

    for (int i = 0; i < 200; i++) mem[i] = DW'($urandom);
    start(1'b1, 1'b1);
    wait_done();

    // Random max pooling; a second run pulse mid-run must be ignored.
    for (int i = 0; i < 200; i++) mem[i] = DW'($urandom);
    start(1'b0, 1'b0);
    while (tcyc - t0 < 19) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_done();

    // Abort with reset mid-run, then a clean rerun from address 0.
    for (int i = 0; i < 200; i++) mem[i] = DW'(i);
    start(1'b1, 1'b0);
    while (tcyc - t0 < 50) @(negedge clk);
    reset = 1'b0;
    active = 1'b0;
    exp_q.delete();
    exp_done = -1;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    start(1'b1, 1'b0);
    wait_done();

    // Two-channel stride-1 instance.
    wcnt_b = 0;
    @(negedge clk);
    run_b = 1'b1;
    @(posedge clk);
    t0b = tcyc;
    active_b = 1'b1;
    @(negedge clk);
    run_b = 1'b0;
    for (int i = 0; i < 300 && active_b; i++) @(negedge clk);
    if (active_b) begin
      check("b_done_timeout", 0, 1);
      active_b = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
